// File: rtl/seq_divider_8_if.sv
// Start/busy/done handshake and operand/result bundle between the ALU control FSM
// and the sequential divider.
interface seq_divider_8_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Results are registered and held until the next accepted start.
module seq_divider_8 #(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  seq_divider_8_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  dvd_shift;
  logic [W-1:0]  dvs;
  logic [W-1:0]  prem;
  logic [W-1:0]  q_shift;
  logic [CW-1:0] count;
  logic          busy_r;
  logic          done_r;
  logic [W-1:0]  quotient_r;
  logic [W-1:0]  remainder_r;
  logic          dz_r;

  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          q_bit;
  logic [W-1:0]  next_rem;

  // The partial remainder is always below the divisor, so the shifted trial fits
  // in W+1 bits and a successful subtract always fits back into W bits.
  always_comb begin
    trial    = {prem, dvd_shift[W-1]};
    diff     = trial - {1'b0, dvs};
    q_bit    = (trial >= {1'b0, dvs});
    next_rem = q_bit ? diff[W-1:0] : trial[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd_shift   <= '0;
      dvs         <= '0;
      prem        <= '0;
      q_shift     <= '0;
      count       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_shift <= bus.dividend;
            dvs       <= bus.divisor;
            prem      <= '0;
            q_shift   <= '0;
            count     <= '0;
            dz_r      <= (bus.divisor == '0);
            // Divide by zero skips iteration and reports all-ones / dividend.
            if (bus.divisor == '0) begin
              state       <= DONE;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prem      <= next_rem;
          q_shift   <= {q_shift[W-2:0], q_bit};
          dvd_shift <= {dvd_shift[W-2:0], 1'b0};
          count     <= count + 1'b1;
          if (count == CW'(W - 1)) begin
            quotient_r  <= {q_shift[W-2:0], q_bit};
            remainder_r <= next_rem;
            state       <= DONE;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider_8.sv
// Directed and randomised checks of seq_divider_8: results, latency, busy window,
// result hold, ignored start, back-to-back operation and asynchronous reset.
module tb_seq_divider_8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_8_if #(.W(W)) bus ();
  seq_divider_8 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int assertions = 0;
  int failures   = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launches one operation and follows it until done (bounded), optionally pulsing
  // a stray start (9/2) before edge N+inject_at.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                               input int inject_at, output int lat,
                               output int busy_cycles, output bit held);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    lat = 0;
    busy_cycles = 0;
    held = 1'b1;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cycles++;
      if (bus.quotient !== last_q || bus.remainder !== last_r) held = 1'b0;
      @(negedge clk);
      if (lat + 1 == inject_at) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
      end else begin
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic checkOp(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input bit exp_dz, input int inject_at, input bit go_idle);
    int lat;
    int busy_cycles;
    bit held;
    int exp_lat;
    applyStimulus(dvd, dvs, inject_at, lat, busy_cycles, held);
    exp_lat = (dvs == '0) ? 0 : W;
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, exp_lat);
    checkOutput({tag, "_held"}, held, 1);
    checkOutput({tag, "_q"}, bus.quotient, exp_q);
    checkOutput({tag, "_r"}, bus.remainder, exp_r);
    checkOutput({tag, "_dz"}, bus.div_by_zero, exp_dz);
    last_q = exp_q;
    last_r = exp_r;
    if (go_idle) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, bus.done, 0);
      checkOutput({tag, "_idle_busy"}, bus.busy, 0);
      checkOutput({tag, "_q_hold"}, bus.quotient, exp_q);
    end
  endtask

  initial begin
    bit saw_done;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_q", bus.quotient, 0);
    checkOutput("reset_r", bus.remainder, 0);
    checkOutput("reset_dz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    checkOp("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, -1, 1'b1);
    checkOp("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, -1, 1'b1);
    checkOp("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, -1, 1'b1);
    checkOp("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, -1, 1'b1);
    checkOp("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, -1, 1'b1);
    checkOp("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, -1, 1'b1);
    checkOp("ignored_start", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 3, 1'b1);
    checkOp("b2b_first", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, -1, 1'b0);
    checkOp("b2b_second", 8'd250, 8'd16, 8'd15, 8'd10, 1'b0, -1, 1'b1);

    // Asynchronous reset partway through 100/7, between edges N+3 and N+4.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", bus.busy, 0);
    checkOutput("async_rst_done", bus.done, 0);
    checkOutput("async_rst_q", bus.quotient, 0);
    checkOutput("async_rst_r", bus.remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checkOutput("after_rst_quiet", saw_done, 0);
    last_q = '0;
    last_r = '0;
    checkOp("post_rst_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, -1, 1'b1);

    for (int i = 0; i < 1200; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 29 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      if (b == '0)
        checkOp("sweep", a, b, 8'd255, a, 1'b1, -1, bit'(i % 2));
      else
        checkOp("sweep", a, b, a / b, a % b, 1'b0, -1, bit'(i % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
